// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and latency classes for the hazard unit
package hazard_pkg;

    // EX-stage operand source select
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    // Producer latency classes: cycles after leaving D until forwardable to EX
    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 4;
    localparam int LAT_DIV  = 8;

endpackage

// File: rtl/scoreboard_array.sv
// rtl/scoreboard_array.sv - per-register latency scoreboard storage
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   freeze             hold every entry unchanged this edge
//   wr_en/addr/lat     merge a new producer latency into one entry
//   rd_addr_a/b        combinational read addresses
//   rd_lat_a/b         remaining latency of the addressed entries
module scoreboard_array #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int LAT_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [LAT_WIDTH-1:0]      wr_lat,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b,
    output logic [LAT_WIDTH-1:0]      rd_lat_a,
    output logic [LAT_WIDTH-1:0]      rd_lat_b
);

    logic [LAT_WIDTH-1:0] sb_q [NUM_REGS];
    logic [LAT_WIDTH-1:0] sb_d [NUM_REGS];

    always_comb begin
        sb_d = sb_q;
        if (!freeze) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sb_q[i] != '0) begin
                    sb_d[i] = sb_q[i] - LAT_WIDTH'(1);
                end
            end
            // Max-merge: a younger short producer never shortens an older long one
            if (wr_en && (wr_lat > sb_d[wr_addr])) begin
                sb_d[wr_addr] = wr_lat;
            end
        end
        sb_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

    assign rd_lat_a = sb_q[rd_addr_a];
    assign rd_lat_b = sb_q[rd_addr_b];

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// rtl/scoreboard_hazard_unit.sv - latency-scoreboard hazard, forwarding and stall-count unit
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   validD, rs1D, rs2D, useRs*D   decode-stage instruction sources
//   rdD, regWriteD, latD          decode-stage destination and producer latency
//   Rs1E, Rs2E, RdM, RdW, RegWrite* EX sources and MEM/WB destinations
//   redirectE, exBusy             taken branch in EX, busy multi-cycle unit
//   stallF/D/E, flushD/E          pipeline register control
//   ForwardAE/BE                  EX operand source select
//   stallCount                    saturating count of stallD cycles
module scoreboard_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int MAX_LAT        = 8,
    parameter int LAT_WIDTH      = $clog2(MAX_LAT + 1),
    parameter int PERF_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      validD,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D,
    input  logic                      useRs1D,
    input  logic                      useRs2D,
    input  logic [REG_ADDR_WIDTH-1:0] rdD,
    input  logic                      regWriteD,
    input  logic [LAT_WIDTH-1:0]      latD,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      redirectE,
    input  logic                      exBusy,
    output logic                      stallF,
    output logic                      stallD,
    output logic                      stallE,
    output logic                      flushD,
    output logic                      flushE,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic [PERF_WIDTH-1:0]     stallCount
);

    localparam logic [LAT_WIDTH-1:0] MAX_LAT_L = LAT_WIDTH'(MAX_LAT);

    logic [LAT_WIDTH-1:0]  lat_rs1;
    logic [LAT_WIDTH-1:0]  lat_rs2;
    logic [LAT_WIDTH-1:0]  lat_wr;
    logic                  haz_d;
    logic                  issue;
    logic                  freeze;
    fwd_sel_t              fwd_a;
    fwd_sel_t              fwd_b;
    logic [PERF_WIDTH-1:0] stall_count_q;
    logic [PERF_WIDTH-1:0] stall_count_d;

    function automatic fwd_sel_t fwd_select(input logic [REG_ADDR_WIDTH-1:0] rs);
        if (RegWriteM && (RdM != '0) && (RdM == rs)) begin
            return FWD_M;
        end else if (RegWriteW && (RdW != '0) && (RdW == rs)) begin
            return FWD_W;
        end
        return FWD_REG;
    endfunction

    scoreboard_array #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_REGS       (NUM_REGS),
        .LAT_WIDTH      (LAT_WIDTH)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .wr_en     (issue),
        .wr_addr   (rdD),
        .wr_lat    (lat_wr),
        .rd_addr_a (rs1D),
        .rd_addr_b (rs2D),
        .rd_lat_a  (lat_rs1),
        .rd_lat_b  (lat_rs2)
    );

    always_comb begin
        lat_wr = (latD > MAX_LAT_L) ? MAX_LAT_L : latD;
        haz_d  = validD && ((useRs1D && (rs1D != '0) && (lat_rs1 != '0)) ||
                            (useRs2D && (rs2D != '0) && (lat_rs2 != '0)));
        // A redirect kills the D instruction, so a busy unit only freezes without one
        freeze = exBusy && !redirectE;
        issue  = validD && !stallD && !redirectE && regWriteD && (rdD != '0);
    end

    // Priority: redirect > busy execute unit > RAW hazard; all quiet in reset
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (rst) begin
            if (redirectE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (exBusy) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
            end else if (haz_d) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_comb begin
        fwd_a     = fwd_select(Rs1E);
        fwd_b     = fwd_select(Rs2E);
        ForwardAE = rst ? fwd_a : FWD_REG;
        ForwardBE = rst ? fwd_b : FWD_REG;
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stallD && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + PERF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stallCount = stall_count_q;

endmodule
